// File: rtl/four_bit_synchronous_counter.sv
// 4-bit synchronous up-counter in T-flip-flop carry-chain form with async active-low clear.
// Define COUNTER_TC_EN to add the combinational terminal-count output tc.

module four_bit_synchronous_counter_tff (
  input  logic clock,
  input  logic clear,
  input  logic t,
  output logic q
);
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) q <= 1'b0;
    else if (t) q <= ~q;
  end
endmodule

module four_bit_synchronous_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       cnt_en,
  output logic [3:0] q
`ifdef COUNTER_TC_EN
  , output logic     tc
`endif
);
  localparam int WIDTH = 4;

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] count;

  // Bit i toggles when enabled and every lower bit is 1; all bits share one clock.
  assign toggle[0] = cnt_en;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_carry
      assign toggle[i] = toggle[i-1] & count[i-1];
    end
    for (i = 0; i < WIDTH; i++) begin : g_bit
      four_bit_synchronous_counter_tff u_tff (
        .clock (clock),
        .clear (clear),
        .t     (toggle[i]),
        .q     (count[i])
      );
    end
  endgenerate

  assign q = count;

`ifdef COUNTER_TC_EN
  // High in the cycle whose next edge wraps F->0; usable as a cascade enable.
  assign tc = cnt_en & (count == 4'hF);
`endif

endmodule

// File: tb/tb_four_bit_synchronous_counter.sv
// Directed, table-driven bench for four_bit_synchronous_counter.
// tc checks are compiled in only when COUNTER_TC_EN is defined.

module tb_four_bit_synchronous_counter;
  logic       clock;
  logic       clear;
  logic       cnt_en;
  logic [3:0] q;
`ifdef COUNTER_TC_EN
  logic       tc;
`endif

  four_bit_synchronous_counter dut (
    .clock  (clock),
    .clear  (clear),
    .cnt_en (cnt_en),
    .q      (q)
`ifdef COUNTER_TC_EN
    , .tc   (tc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       clear;
    logic       cnt_en;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_lo, run_hi, wraps;
  logic [3:0] prev_q;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic c, input logic e, input logic [3:0] x);
    vec_t v;
    v.clear = c; v.cnt_en = e; v.exp_q = x;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled 1 unit after the edge.
  task automatic edge_then_sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset hold
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 4'h0);
    // Release without enable
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 4'h0);
    // 40 enabled edges: 1..15,0,1..15,0,1..8
    run_lo = vecs.size();
    for (int k = 1; k <= 40; k++) add(1'b1, 1'b1, 4'(k % 16));
    run_hi = vecs.size() - 1;
    // Count on from 8 up to 5 (9..F,0..5), hold 4 edges, then 6
    for (int k = 9; k <= 21; k++) add(1'b1, 1'b1, 4'(k % 16));
    for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 4'h5);
    add(1'b1, 1'b1, 4'h6);

    clear  = 1'b0;
    cnt_en = 1'b0;
    #1;
    check("reset_async_t0", q, 4'h0);
    @(posedge clock); #1;

    wraps  = 0;
    prev_q = q;
    for (int k = 0; k < vecs.size(); k++) begin
      clear  = vecs[k].clear;
      cnt_en = vecs[k].cnt_en;
      edge_then_sample();
      check($sformatf("vec%0d", k), q, vecs[k].exp_q);
      if (k >= run_lo && k <= run_hi && prev_q == 4'hF && q == 4'h0) wraps++;
      prev_q = q;
    end
    check("wrap_count", 4'(wraps), 4'd2);

    // q: 6 -> A
    cnt_en = 1'b1;
    repeat (4) edge_then_sample();
    check("reach_a", q, 4'hA);

    // Glitch on cnt_en between edges, low at the edge: hold
    cnt_en = 1'b0; #1 cnt_en = 1'b1; #1 cnt_en = 1'b0;
    edge_then_sample();
    check("enable_glitch_hold", q, 4'hA);

    // Async clear mid-cycle, before any edge
    #3 clear = 1'b0;
    #1 check("async_clear_mid", q, 4'h0);
    cnt_en = 1'b1;
    edge_then_sample();
    check("clear_priority_edge", q, 4'h0);
    cnt_en = 1'bx;
    edge_then_sample();
    check("clear_x_enable", q, 4'h0);
`ifdef COUNTER_TC_EN
    check("tc_during_clear", {3'b0, tc}, 4'h0);
`endif
    cnt_en = 1'b1;
    clear  = 1'b1;
    edge_then_sample();
    check("restart_after_clear", q, 4'h1);

    // q: 1 -> F
    repeat (14) edge_then_sample();
    check("reach_f", q, 4'hF);
`ifdef COUNTER_TC_EN
    check("tc_high_at_f", {3'b0, tc}, 4'h1);
    cnt_en = 1'b0;
    #1 check("tc_low_no_en", {3'b0, tc}, 4'h0);
    edge_then_sample();
    check("hold_f", q, 4'hF);
    cnt_en = 1'b1;
    #1 check("tc_high_again", {3'b0, tc}, 4'h1);
`endif
    edge_then_sample();
    check("wrap_f_to_0", q, 4'h0);
`ifdef COUNTER_TC_EN
    check("tc_low_after_wrap", {3'b0, tc}, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
